// File: rtl/mult_hilo_unit_if.sv
// HI/LO multiplier bus between the EX stage and mult_hilo_unit.
//   master : pipeline side, drives MULTU/MFHI/MFLO/MTHI/MTLO requests and operands
//   slave  : multiplier side, returns rd_data, hi, lo, busy, done, stall
interface mult_hilo_unit_if #(
  parameter int unsigned DATA_W = 32
);
  logic              mult_start;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              rd_hi_req;
  logic              rd_lo_req;
  logic              wr_hi_req;
  logic              wr_lo_req;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              busy;
  logic              done;
  logic              stall;

  modport master (
    output mult_start, src_a, src_b, rd_hi_req, rd_lo_req, wr_hi_req, wr_lo_req, wr_data,
    input  rd_data, hi, lo, busy, done, stall
  );

  modport slave (
    input  mult_start, src_a, src_b, rd_hi_req, rd_lo_req, wr_hi_req, wr_lo_req, wr_data,
    output rd_data, hi, lo, busy, done, stall
  );
endinterface

// File: rtl/mult_hilo_unit.sv
// Multi-cycle unsigned shift-add multiplier with architectural HI/LO registers.
// Ports:
//   clk   : clock, all state updates on rising edge
//   rst   : synchronous active-high reset
//   bus   : mult_hilo_unit_if.slave
//           requests  mult_start/src_a/src_b (MULTU), rd_hi_req/rd_lo_req (MFHI/MFLO),
//                     wr_hi_req/wr_lo_req/wr_data (MTHI/MTLO)
//           responses rd_data (comb), hi, lo, busy, done, stall (comb)
module mult_hilo_unit #(
  parameter int unsigned DATA_W = 32
) (
  input logic            clk,
  input logic            rst,
  mult_hilo_unit_if.slave bus
);

  localparam int unsigned CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned PROD_W = 2 * DATA_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] prod_step_c;
  logic [DATA_W:0]   sum_c;
  logic [CNT_W-1:0]  cnt;
  logic              busy_q;
  logic              done_q;
  logic              load_c;
  logic              step_c;
  logic              last_c;
  logic              stall_c;
  logic              any_req_c;

  // Any HI/LO access or a new multiply collides with a multiply in flight
  assign any_req_c = bus.mult_start | bus.rd_hi_req | bus.rd_lo_req |
                     bus.wr_hi_req | bus.wr_lo_req;
  assign stall_c   = busy_q & any_req_c;

  // One shift-add iteration; the top product bit is the carry of the upper-half add
  always_comb begin
    sum_c = prod[PROD_W-1:DATA_W];
    if (prod[0]) begin
      sum_c = prod[PROD_W-1:DATA_W] + {1'b0, mcand};
    end
    prod_step_c = {sum_c, prod[DATA_W-1:0]} >> 1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt == RUN);
      done_q <= (state_nxt == DONE);
    end
  end

  // Next-state and datapath controls; DONE accepts a new start just like IDLE
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    step_c    = 1'b0;
    last_c    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (bus.mult_start) begin
          load_c    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        step_c = 1'b1;
        if (cnt == CNT_W'(DATA_W - 1)) begin
          last_c    = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Multiplicand, product and iteration counter
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      prod  <= '0;
      cnt   <= '0;
    end else if (load_c) begin
      mcand <= bus.src_a;
      prod  <= {1'b0, {DATA_W{1'b0}}, bus.src_b};
      cnt   <= '0;
    end else if (step_c) begin
      prod  <= prod_step_c;
      cnt   <= cnt + CNT_W'(1);
    end
  end

  // HI/LO: the finishing multiply wins; MTHI/MTLO only land when not stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (last_c) begin
      hi_q <= prod_step_c[2*DATA_W-1:DATA_W];
      lo_q <= prod_step_c[DATA_W-1:0];
    end else begin
      if (bus.wr_hi_req && !stall_c) begin
        hi_q <= bus.wr_data;
      end
      if (bus.wr_lo_req && !stall_c) begin
        lo_q <= bus.wr_data;
      end
    end
  end

  // MFHI has priority over MFLO
  assign bus.rd_data = bus.rd_hi_req ? hi_q :
                       bus.rd_lo_req ? lo_q : '0;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.stall   = stall_c;

endmodule

// File: tb/tb_mult_hilo_unit.sv
module tb_mult_hilo_unit;

  localparam int unsigned W = 32;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  // Reference architectural state, updated from program-order semantics
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  mult_hilo_unit_if #(.DATA_W(W)) bus ();

  mult_hilo_unit #(.DATA_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.mult_start = 1'b0;
    bus.src_a      = '0;
    bus.src_b      = '0;
    bus.rd_hi_req  = 1'b0;
    bus.rd_lo_req  = 1'b0;
    bus.wr_hi_req  = 1'b0;
    bus.wr_lo_req  = 1'b0;
    bus.wr_data    = '0;
  endtask

  task automatic rand_inputs();
    bus.mult_start = 1'($urandom_range(0, 1));
    bus.src_a      = $urandom;
    bus.src_b      = $urandom;
    bus.rd_hi_req  = 1'($urandom_range(0, 1));
    bus.rd_lo_req  = 1'($urandom_range(0, 1));
    bus.wr_hi_req  = 1'($urandom_range(0, 1));
    bus.wr_lo_req  = 1'($urandom_range(0, 1));
    bus.wr_data    = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rand_inputs();
    tick();
    rand_inputs();
    #1;
    m_hi = '0;
    m_lo = '0;
    tests_run++; if (bus.hi !== m_hi) begin tests_failed++; $display("FAIL reset_hi got=%h exp=%h", bus.hi, m_hi); end
    tests_run++; if (bus.lo !== m_lo) begin tests_failed++; $display("FAIL reset_lo got=%h exp=%h", bus.lo, m_lo); end
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    tests_run++; if (bus.stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
    tests_run++; if (bus.rd_data !== '0) begin tests_failed++; $display("FAIL reset_rd_data got=%h exp=0", bus.rd_data); end
    tick();
    rst = 1'b0;
    clear_inputs();
    #1;
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy_after got=%b exp=0", bus.busy); end
    tick();
  endtask

  task automatic test_full_range();
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
    logic           exp_busy;
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    p = 64'(a) * 64'(b);
    for (int c = 0; c <= 34; c++) begin
      bus.mult_start = (c == 0);
      bus.src_a      = a;
      bus.src_b      = b;
      #1;
      if (c == 33) begin m_hi = p[2*W-1:W]; m_lo = p[W-1:0]; end
      exp_busy = (c >= 1 && c <= 32);
      tests_run++; if (bus.busy !== exp_busy) begin tests_failed++; $display("FAIL full_busy c=%0d got=%b exp=%b", c, bus.busy, exp_busy); end
      tests_run++; if (bus.done !== (c == 33)) begin tests_failed++; $display("FAIL full_done c=%0d got=%b exp=%b", c, bus.done, (c == 33)); end
      tests_run++; if (bus.hi !== m_hi) begin tests_failed++; $display("FAIL full_hi c=%0d got=%h exp=%h", c, bus.hi, m_hi); end
      tests_run++; if (bus.lo !== m_lo) begin tests_failed++; $display("FAIL full_lo c=%0d got=%h exp=%h", c, bus.lo, m_lo); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_stall_read();
    logic [2*W-1:0] p;
    logic           exp_stall;
    logic [W-1:0]   old_hi;
    old_hi = m_hi;
    p = 64'(32'd7) * 64'(32'd6);
    for (int c = 0; c <= 34; c++) begin
      bus.mult_start = (c == 0);
      bus.src_a      = 32'd7;
      bus.src_b      = 32'd6;
      bus.rd_hi_req  = (c >= 5 && c <= 33);
      bus.rd_lo_req  = (c == 34);
      #1;
      if (c == 33) begin m_hi = p[2*W-1:W]; m_lo = p[W-1:0]; end
      exp_stall = (c >= 5 && c <= 32);
      tests_run++; if (bus.stall !== exp_stall) begin tests_failed++; $display("FAIL rd_stall c=%0d got=%b exp=%b", c, bus.stall, exp_stall); end
      if (c == 5) begin
        tests_run++; if (bus.rd_data !== old_hi) begin tests_failed++; $display("FAIL rd_during_run got=%h exp=%h", bus.rd_data, old_hi); end
      end
      if (c == 33) begin
        tests_run++; if (bus.rd_data !== m_hi) begin tests_failed++; $display("FAIL rd_mfhi got=%h exp=%h", bus.rd_data, m_hi); end
      end
      if (c == 34) begin
        tests_run++; if (bus.rd_data !== 32'd42) begin tests_failed++; $display("FAIL rd_mflo got=%h exp=%h", bus.rd_data, 32'd42); end
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] p1;
    logic [2*W-1:0] p2;
    logic           exp_busy;
    logic           exp_done;
    p1 = 64'(32'h0001_0000) * 64'(32'h0001_0000);
    p2 = 64'(32'd3) * 64'(32'd5);
    for (int c = 0; c <= 67; c++) begin
      bus.mult_start = (c == 0 || c == 33);
      bus.src_a      = (c < 33) ? 32'h0001_0000 : 32'd3;
      bus.src_b      = (c < 33) ? 32'h0001_0000 : 32'd5;
      #1;
      if (c == 33) begin m_hi = p1[2*W-1:W]; m_lo = p1[W-1:0]; end
      if (c == 66) begin m_hi = p2[2*W-1:W]; m_lo = p2[W-1:0]; end
      exp_busy = (c >= 1 && c <= 32) || (c >= 34 && c <= 65);
      exp_done = (c == 33 || c == 66);
      tests_run++; if (bus.busy !== exp_busy) begin tests_failed++; $display("FAIL b2b_busy c=%0d got=%b exp=%b", c, bus.busy, exp_busy); end
      tests_run++; if (bus.done !== exp_done) begin tests_failed++; $display("FAIL b2b_done c=%0d got=%b exp=%b", c, bus.done, exp_done); end
      tests_run++; if (bus.hi !== m_hi) begin tests_failed++; $display("FAIL b2b_hi c=%0d got=%h exp=%h", c, bus.hi, m_hi); end
      tests_run++; if (bus.lo !== m_lo) begin tests_failed++; $display("FAIL b2b_lo c=%0d got=%h exp=%h", c, bus.lo, m_lo); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_abort();
    logic exp_busy;
    for (int c = 0; c <= 45; c++) begin
      clear_inputs();
      rst = (c == 12);
      if (c == 0) begin
        bus.mult_start = 1'b1;
        bus.src_a      = 32'd9;
        bus.src_b      = 32'd9;
      end
      if (c == 10) begin
        bus.mult_start = 1'b1;
        bus.src_a      = $urandom;
        bus.src_b      = $urandom;
        bus.wr_lo_req  = 1'b1;
        bus.wr_data    = $urandom;
      end
      #1;
      if (c == 13) begin m_hi = '0; m_lo = '0; end
      exp_busy = (c >= 1 && c <= 12);
      if (c == 10) begin
        tests_run++; if (bus.stall !== 1'b1) begin tests_failed++; $display("FAIL abort_stall got=%b exp=1", bus.stall); end
      end
      tests_run++; if (bus.busy !== exp_busy) begin tests_failed++; $display("FAIL abort_busy c=%0d got=%b exp=%b", c, bus.busy, exp_busy); end
      tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL abort_done c=%0d got=%b exp=0", c, bus.done); end
      tests_run++; if (bus.hi !== m_hi) begin tests_failed++; $display("FAIL abort_hi c=%0d got=%h exp=%h", c, bus.hi, m_hi); end
      tests_run++; if (bus.lo !== m_lo) begin tests_failed++; $display("FAIL abort_lo c=%0d got=%h exp=%h", c, bus.lo, m_lo); end
      tick();
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_mt_mf();
    for (int c = 0; c <= 3; c++) begin
      clear_inputs();
      if (c == 0) begin bus.wr_hi_req = 1'b1; bus.wr_data = 32'h0000_1234; end
      if (c == 1) begin bus.wr_lo_req = 1'b1; bus.wr_data = 32'hDEAD_BEEF; end
      if (c == 2) begin bus.rd_hi_req = 1'b1; bus.rd_lo_req = 1'b1; end
      if (c == 3) begin bus.rd_lo_req = 1'b1; end
      #1;
      if (c == 1) m_hi = 32'h0000_1234;
      if (c == 2) m_lo = 32'hDEAD_BEEF;
      tests_run++; if (bus.hi !== m_hi) begin tests_failed++; $display("FAIL mt_hi c=%0d got=%h exp=%h", c, bus.hi, m_hi); end
      tests_run++; if (bus.lo !== m_lo) begin tests_failed++; $display("FAIL mt_lo c=%0d got=%h exp=%h", c, bus.lo, m_lo); end
      tests_run++; if (bus.stall !== 1'b0) begin tests_failed++; $display("FAIL mt_stall c=%0d got=%b exp=0", c, bus.stall); end
      if (c == 2) begin
        tests_run++; if (bus.rd_data !== 32'h0000_1234) begin tests_failed++; $display("FAIL mf_both got=%h exp=%h", bus.rd_data, 32'h0000_1234); end
      end
      if (c == 3) begin
        tests_run++; if (bus.rd_data !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL mf_lo got=%h exp=%h", bus.rd_data, 32'hDEAD_BEEF); end
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_random();
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
    logic [W-1:0]   exp_rd;
    logic [W-1:0]   wdata;
    logic           do_wr;
    logic           exp_stall;
    for (int n = 0; n < 10; n++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 4))
        0: a = '0;
        1: b = 32'd1;
        2: begin a = 32'hFFFF_FFFF; b = 32'h8000_0001; end
        default: ;
      endcase
      p     = 64'(a) * 64'(b);
      do_wr = 1'($urandom_range(0, 1));
      wdata = $urandom;
      for (int c = 0; c <= 34; c++) begin
        clear_inputs();
        if (c == 0) begin
          bus.mult_start = 1'b1;
          bus.src_a      = a;
          bus.src_b      = b;
          bus.wr_hi_req  = do_wr;
          bus.wr_data    = wdata;
          bus.rd_lo_req  = 1'($urandom_range(0, 1));
        end else if (c <= 32) begin
          rand_inputs();
        end
        #1;
        if (c == 1 && do_wr) m_hi = wdata;
        if (c == 33) begin m_hi = p[2*W-1:W]; m_lo = p[W-1:0]; end
        exp_rd = bus.rd_hi_req ? m_hi : (bus.rd_lo_req ? m_lo : '0);
        exp_stall = (c >= 1 && c <= 32) &&
                    (bus.mult_start || bus.rd_hi_req || bus.rd_lo_req || bus.wr_hi_req || bus.wr_lo_req);
        tests_run++; if (bus.stall !== exp_stall) begin tests_failed++; $display("FAIL rnd_stall n=%0d c=%0d got=%b exp=%b", n, c, bus.stall, exp_stall); end
        tests_run++; if (bus.rd_data !== exp_rd) begin tests_failed++; $display("FAIL rnd_rd n=%0d c=%0d got=%h exp=%h", n, c, bus.rd_data, exp_rd); end
        tests_run++; if (bus.done !== (c == 33)) begin tests_failed++; $display("FAIL rnd_done n=%0d c=%0d got=%b exp=%b", n, c, bus.done, (c == 33)); end
        tests_run++; if (bus.hi !== m_hi) begin tests_failed++; $display("FAIL rnd_hi n=%0d c=%0d got=%h exp=%h", n, c, bus.hi, m_hi); end
        tests_run++; if (bus.lo !== m_lo) begin tests_failed++; $display("FAIL rnd_lo n=%0d c=%0d got=%h exp=%h", n, c, bus.lo, m_lo); end
        tick();
      end
    end
    clear_inputs();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    m_hi         = '0;
    m_lo         = '0;
    rst          = 1'b1;
    clear_inputs();
    test_reset();
    test_full_range();
    test_stall_read();
    test_back_to_back();
    test_abort();
    test_mt_mf();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mult_hilo_unit.md
# mult_hilo_unit

Multi-cycle unsigned multiplier with architectural HI/LO registers for the MIPS pipeline CPU. It sits beside the EX-stage ALU. It executes MULTU (funct 25) as a 32-iteration shift-add sequence, services MFHI/MFLO (funct 16/18) and MTHI/MTLO (funct 17/19), and raises a stall to hazard control whenever an EX-stage HI/LO access collides with an in-flight multiply.

## Interface
Parameters:
- DATA_W, 32, operand width; the product is 2*DATA_W wide; iteration count = DATA_W

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- mult_start  in  1  MULTU in EX this cycle
- src_a  in  DATA_W  multiplicand (rs value)
- src_b  in  DATA_W  multiplier (rt value)
- rd_hi_req  in  1  MFHI in EX
- rd_lo_req  in  1  MFLO in EX
- wr_hi_req  in  1  MTHI in EX
- wr_lo_req  in  1  MTLO in EX
- wr_data  in  DATA_W  value for MTHI/MTLO (rs value)
- rd_data  out  DATA_W  combinational; hi if rd_hi_req, else lo if rd_lo_req, else 0
- hi  out  DATA_W  HI register
- lo  out  DATA_W  LO register
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse in DONE
- stall  out  1  combinational; freeze IF/ID/EX and bubble MEM

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: on mult_start, latch src_a into the multiplicand register. Load the 2*DATA_W+1-bit product register with {carry 0, DATA_W zeros, src_b}. Clear the iteration counter. Go to RUN.
- RUN: each cycle, if product[0]=1, upper half += multiplicand using a DATA_W+1-bit add, with the carry going to the extra bit. Then shift the whole register right by 1. Increment the counter.
  - After iteration DATA_W (counter DATA_W-1 at the edge), load hi=product[2W-1:W] and lo=product[W-1:0] at that same edge. Go to DONE.
- DONE: done=1. A new mult_start is accepted exactly as in IDLE; otherwise go to IDLE.
- Arithmetic: exact unsigned 64-bit product, no truncation or overflow.
- stall = busy & (mult_start | rd_hi_req | rd_lo_req | wr_hi_req | wr_lo_req).
  - While stalled, the request is ignored; the pipeline re-presents it.
  - stall is never asserted in IDLE or DONE.
- MTHI/MTLO, when not stalled, write hi/lo at the edge.
  - If mult_start and a write are both present in IDLE/DONE, the write lands but is overwritten when the multiply completes (program-order result).
- A read and mult_start in the same cycle: the read returns the current hi/lo, and the start is accepted.
- rd_hi_req and rd_lo_req both set: HI has priority.
- Reset (including mid-RUN): state=IDLE, hi=lo=0, counter=0, product=0, busy=0, done=0, stall=0. A partial product is discarded.

## Timing
- mult_start in cycle 0 (IDLE) → RUN cycles 1..32 → DONE in cycle 33 with new hi/lo visible and done=1 → IDLE in cycle 34 unless restarted.
- Latency: 33 cycles start-to-result. Issue interval: 33 cycles (a back-to-back start is accepted in DONE).
- busy=1 exactly in cycles 1..32.
- The earliest unstalled MFHI/MFLO after MULTU in cycle 0 is in cycle 33.
- rd_data and stall are purely combinational from the current state and the requests.
- MTHI/MTLO: 1-cycle write, visible on hi/lo in the next cycle.

## Test plan
- Reset: assert rst for 2 cycles with random inputs → hi=lo=0, busy=done=stall=0, rd_data=0.
- 0xFFFFFFFF × 0xFFFFFFFF, start cycle 0 → busy cycles 1..32; cycle 33 done=1, hi=0xFFFFFFFE, lo=0x00000001; cycle 34 done=0.
- 7 × 6 start cycle 0, rd_hi_req held from cycle 5 → stall=1 cycles 5..32; cycle 33 stall=0, rd_data=0. MFLO in cycle 34 → rd_data=42.
- 0x00010000 × 0x00010000 start cycle 0, second start 3 × 5 in cycle 33 → cycle 33 hi=1, lo=0. Busy again cycles 34..65. Cycle 66 hi=0, lo=15.
- Start 9 × 9; second mult_start and wr_lo_req in cycle 10 → stall=1, no effect. rst in cycle 12 → cycle 13 IDLE, hi=lo=0, and no done pulse ever.
- IDLE: wr_hi 0x00001234 cycle 0, wr_lo 0xDEADBEEF cycle 1. Cycle 2 with rd_hi_req=rd_lo_req=1 → rd_data=0x00001234. Cycle 3 with rd_lo_req only → rd_data=0xDEADBEEF.
